// File: rtl/sr_ff_bank.sv
// Bank of WIDTH single-bit storage elements with a runtime-selectable D/T/SR/JK function.
// Counts SR collision edges (saturating) and flags per-channel changes as one-cycle pulses.
module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg,
    output logic             coll,
    output logic [CNT_W-1:0] coll_cnt
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_SR = 2'b10;
    localparam logic [1:0]       MODE_JK = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_nxt;
    logic             coll_edge;

    function automatic logic sr_resolve(input logic cur);
        case (SR_POLICY)
            1:       sr_resolve = 1'b1;
            2:       sr_resolve = 1'b0;
            3:       sr_resolve = ~cur;
            default: sr_resolve = cur;
        endcase
    endfunction

    // Each channel only looks at its own a/b bits, so unknowns cannot leak sideways.
    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_D: q_nxt[i] = a[i];
                MODE_T: q_nxt[i] = q[i] ^ a[i];
                MODE_SR: begin
                    case ({a[i], b[i]})
                        2'b01:   q_nxt[i] = 1'b0;
                        2'b10:   q_nxt[i] = 1'b1;
                        2'b11:   q_nxt[i] = sr_resolve(q[i]);
                        default: q_nxt[i] = q[i];
                    endcase
                end
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b01:   q_nxt[i] = 1'b0;
                        2'b10:   q_nxt[i] = 1'b1;
                        2'b11:   q_nxt[i] = ~q[i];
                        default: q_nxt[i] = q[i];
                    endcase
                end
                default: q_nxt[i] = q[i];
            endcase
        end
    end

    assign coll_edge = (mode == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RST_VAL;
            chg      <= '0;
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else if (en) begin
            q    <= q_nxt;
            chg  <= q ^ q_nxt;
            coll <= coll_edge;
            if (coll_edge && (coll_cnt != CNT_MAX)) begin
                coll_cnt <= coll_cnt + 1'b1;
            end
        end else begin
            chg  <= '0;
            coll <= 1'b0;
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Drives five sr_ff_bank variants (each SR policy, a non-zero reset value, a 2-bit counter)
// with shared stimulus; expected outputs are queued by the driver and checked by a monitor.
module tb_sr_ff_bank;

    localparam int N = 5;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;

    logic [7:0] q_w   [N];
    logic [7:0] qn_w  [N];
    logic [7:0] chg_w [N];
    logic       coll_w[N];
    logic [7:0] cnt8  [4];
    logic [1:0] cnt2;

    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q_w[0]), .q_n(qn_w[0]), .chg(chg_w[0]), .coll(coll_w[0]), .coll_cnt(cnt8[0]));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_POLICY(1), .CNT_W(8)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q_w[1]), .q_n(qn_w[1]), .chg(chg_w[1]), .coll(coll_w[1]), .coll_cnt(cnt8[1]));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_POLICY(2), .CNT_W(8)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q_w[2]), .q_n(qn_w[2]), .chg(chg_w[2]), .coll(coll_w[2]), .coll_cnt(cnt8[2]));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_POLICY(3), .CNT_W(8)) u_p3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q_w[3]), .q_n(qn_w[3]), .chg(chg_w[3]), .coll(coll_w[3]), .coll_cnt(cnt8[3]));
    sr_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_POLICY(0), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q_w[4]), .q_n(qn_w[4]), .chg(chg_w[4]), .coll(coll_w[4]), .coll_cnt(cnt2));

    typedef struct packed {
        logic [N-1:0][7:0] q;
        logic [N-1:0][7:0] chg;
        logic [N-1:0]      coll;
        logic [N-1:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq   [N];
    int         mcnt [N];
    int         pol  [N] = '{0, 1, 2, 3, 0};
    int         cmax [N] = '{255, 255, 255, 255, 3};
    logic [7:0] rv   [N] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge's inputs and push the outputs the specification predicts after that edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] av, input logic [7:0] bv);
        exp_t ex;
        logic collide;
        @(negedge clk);
        #1;
        rst = r; en = e; mode = m; a = av; b = bv;
        collide = (m == 2'b10) && ((av & bv) != 8'h00);
        for (int k = 0; k < N; k++) begin
            logic [7:0] nq;
            nq = mq[k];
            if (r) begin
                mq[k]     = rv[k];
                mcnt[k]   = 0;
                ex.chg[k] = 8'h00;
                ex.coll[k] = 1'b0;
            end else if (!e) begin
                ex.chg[k] = 8'h00;
                ex.coll[k] = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    bit s, rr, cur;
                    s = av[i]; rr = bv[i]; cur = mq[k][i];
                    if (m == 2'b00)      nq[i] = s;
                    else if (m == 2'b01) nq[i] = s ? !cur : cur;
                    else if (s && rr) begin
                        if (m == 2'b11)     nq[i] = !cur;
                        else if (pol[k] == 1) nq[i] = 1'b1;
                        else if (pol[k] == 2) nq[i] = 1'b0;
                        else if (pol[k] == 3) nq[i] = !cur;
                        else                  nq[i] = cur;
                    end else if (s)  nq[i] = 1'b1;
                    else if (rr)     nq[i] = 1'b0;
                end
                ex.chg[k]  = mq[k] ^ nq;
                ex.coll[k] = collide;
                if (collide && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
                mq[k] = nq;
            end
            ex.q[k]   = mq[k];
            ex.cnt[k] = 8'(mcnt[k]);
        end
        sb.push_back(ex);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                for (int k = 0; k < N; k++) begin
                    chk($sformatf("q[%0d]", k),    {24'h0, q_w[k]},   {24'h0, ex.q[k]});
                    chk($sformatf("q_n[%0d]", k),  {24'h0, qn_w[k]},  {24'h0, ~ex.q[k]});
                    chk($sformatf("chg[%0d]", k),  {24'h0, chg_w[k]}, {24'h0, ex.chg[k]});
                    chk($sformatf("coll[%0d]", k), {31'h0, coll_w[k]}, {31'h0, ex.coll[k]});
                    chk($sformatf("coll_cnt[%0d]", k),
                        (k < 4) ? {24'h0, cnt8[k]} : {30'h0, cnt2}, {24'h0, ex.cnt[k]});
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst = 1'b0; en = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00;
        for (int k = 0; k < N; k++) begin mq[k] = 8'h00; mcnt[k] = 0; end

        step(1'b1, 1'b1, 2'b00, 8'hFF, 8'h00);
        // D mode, then a disabled edge
        step(1'b0, 1'b1, 2'b00, 8'h3C, 8'h5A);
        step(1'b0, 1'b1, 2'b00, 8'h3F, 8'hA5);
        step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        // T mode twice from 0F
        step(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00);
        step(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00);
        // SR collision under each policy from 0F
        step(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00);
        step(1'b0, 1'b1, 2'b10, 8'hFF, 8'hFF);
        // JK from 0F: toggle is not a collision
        step(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00);
        step(1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 2'b11, 8'h0F, 8'hF0);
        // Saturation of the 2-bit counter, hold under en=0, clear on reset
        step(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b10, 8'h01, 8'h01);
        step(1'b0, 1'b0, 2'b10, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 2'b10, 8'hFF, 8'hFF);
        // SR without collision, then random traffic
        step(1'b0, 1'b1, 2'b10, 8'hF0, 8'h0C);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
